uart_imem_loader: RTL and testbench
===================================

// Module: uart_imem_loader
// PURPOSE
//  Boot loader upstream of the single-cycle core's instruction memory.
//  - Receives a program image over a UART 8N1 serial line.
//  - Assembles the bytes into 32-bit words and writes each word into instruction memory.
//  - Holds the core in reset until the whole image is loaded.
//  - Replaces the $readmemh preload, so programs change without resynthesis.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200 baud); must be >= 8
//  WORDS         32   words in one image; equals instruction-memory depth
//  ADDR_W        5    imem word-address width; 2**ADDR_W >= WORDS
// PORTS
//  clk         in   1       system clock (fast clock, not the divided core clock)
//  rst         in   1       reset, asynchronous, active-high
//  uart_rx     in   1       serial input, idle high, asynchronous to clk
//  imem_we     out  1       one-cycle write strobe to instruction memory
//  imem_addr   out  ADDR_W  word address for imem_we
//  imem_wdata  out  32      word for imem_we
//  core_rst    out  1       reset to the core; high while loading
//  load_done   out  1       image fully written
//  frame_err   out  1       sticky: a stop bit was sampled low
//  csum_err    out  1       sticky checksum mismatch (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, load_done=0, frame_err=0, csum_err=0.
//  Internal state also clears on reset: FSMs, counters, partial word, sync flops (reset to 1).
//  Reset mid-load: the partial word is discarded, the image restarts at address 0, and core_rst reasserts.
//  uart_rx: 2-flop synchronizer; all sampling uses the synchronized value.
//  RX FSM (states IDLE, START, DATA, STOP):
//   - IDLE -> START on a synchronized falling edge.
//   - START: wait CLKS_PER_BIT/2 cycles, then resample. Sample 1 = glitch, return to IDLE. Sample 0 -> DATA.
//   - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
//   - STOP: sample after CLKS_PER_BIT cycles.
//       - Stop bit 1: byte_valid pulses for 1 cycle.
//       - Stop bit 0: set frame_err, drop the byte, go to IDLE.
//   - A new start edge is accepted starting the cycle after STOP.
//  Word assembly:
//   - Little-endian: the 1st byte received goes to [7:0], the 4th byte to [31:24].
//   - A 2-bit byte counter wraps 3->0 on each 4th byte.
//   - Dropped (framing-error) bytes do not advance the byte counter.
//  Write:
//   - On the 4th byte_valid, imem_we=1 in the next cycle.
//   - imem_addr = word counter; imem_wdata = assembled word.
//   - The word counter increments when imem_we is high.
//  Loader FSM (LOADING, DONE):
//   - In LOADING, the final data write takes the FSM to DONE on the following cycle.
//   - In DONE: load_done=1 and core_rst=0. Both are registered, 1 cycle after the final imem_we.
//   - In DONE, all further bytes are ignored and no writes occur until rst.
//   - frame_err does not block loading.
// CONFIGURATION
//  UART_LDR_CHECKSUM_EN defined:
//   - After WORDS words, one extra byte is received: the 8-bit modulo-256 sum of all image bytes.
//   - Match: go to DONE.
//   - Mismatch: set csum_err; core_rst stays 1 and load_done stays 0 until rst.
//   - No imem write is issued for the checksum byte.
//  Macro undefined:
//   - No checksum byte; DONE follows the last word.
//   - csum_err is tied 0.
// TESTING
//  1. Reset with uart_rx=1 and no traffic -> core_rst=1, imem_we never pulses, all other outputs 0.
//  2. Send bytes 13 05 00 00 -> exactly one imem_we pulse, imem_addr=0, imem_wdata=32'h00000513.
//  3. Send a full 32-word image (128 bytes) -> 32 writes at addresses 0..31 in order.
//     core_rst falls and load_done rises 1 cycle after the 32nd imem_we.
//     An extra byte sent afterwards produces no write.
//  4. Send a byte with stop bit 0, then 13 05 00 00 -> frame_err=1; the next write is at addr 0 with data 32'h00000513.
//  5. A low pulse of CLKS_PER_BIT/4 cycles on uart_rx -> no byte and no frame_err.
//     Assert rst after 2 bytes -> the next 4 bytes write address 0.
//  6. With UART_LDR_CHECKSUM_EN: a correct checksum gives load_done=1.
//     A checksum off by 1 gives csum_err=1 and core_rst held at 1.

Source files
------------

// File: rtl/uart_imem_loader.sv
// UART 8N1 boot loader: assembles little-endian 32-bit words and writes them into instruction memory.
// Optional trailing checksum byte enabled by defining UART_LDR_CHECKSUM_EN.
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORDS        = 32,
    parameter int ADDR_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              frame_err,
    output logic              csum_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]     CNT_FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]     CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {LD_LOADING, LD_CSUM, LD_DONE, LD_CSUM_BAD} ld_state_e;

    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e         rx_state_q, rx_state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_err_q, frame_err_d;
    ld_state_e         ld_state_q, ld_state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       word_buf_q, word_buf_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              load_done_q, load_done_d;
`ifdef UART_LDR_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              csum_err_q, csum_err_d;
`endif

    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = frame_err_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                // Mid-start-bit resample rejects short low glitches
                if (cnt_q == CNT_HALF) begin
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) byte_valid_d = 1'b1;
                    else           frame_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        ld_state_d   = ld_state_q;
        byte_cnt_d   = byte_cnt_q;
        word_buf_d   = word_buf_q;
        word_cnt_d   = imem_we_q ? word_cnt_q + 1'b1 : word_cnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_rst_d   = core_rst_q;
        load_done_d  = load_done_q;
`ifdef UART_LDR_CHECKSUM_EN
        sum_d        = sum_q;
        csum_err_d   = csum_err_q;
`endif
        case (ld_state_q)
            LD_LOADING: begin
                if (byte_valid_q) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef UART_LDR_CHECKSUM_EN
                    sum_d = sum_q + shift_q;
`endif
                    case (byte_cnt_q)
                        2'd0: word_buf_d[7:0]   = shift_q;
                        2'd1: word_buf_d[15:8]  = shift_q;
                        2'd2: word_buf_d[23:16] = shift_q;
                        default: begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = word_cnt_q;
                            imem_wdata_d = {shift_q, word_buf_q};
                        end
                    endcase
                end
                if (imem_we_q && word_cnt_q == LAST_ADDR) begin
`ifdef UART_LDR_CHECKSUM_EN
                    ld_state_d = LD_CSUM;
`else
                    ld_state_d  = LD_DONE;
                    core_rst_d  = 1'b0;
                    load_done_d = 1'b1;
`endif
                end
            end
`ifdef UART_LDR_CHECKSUM_EN
            LD_CSUM: begin
                if (byte_valid_q) begin
                    if (shift_q == sum_q) begin
                        ld_state_d  = LD_DONE;
                        core_rst_d  = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        ld_state_d = LD_CSUM_BAD;
                        csum_err_d = 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ld_state_q   <= LD_LOADING;
            byte_cnt_q   <= '0;
            word_buf_q   <= '0;
            word_cnt_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            load_done_q  <= 1'b0;
`ifdef UART_LDR_CHECKSUM_EN
            sum_q        <= '0;
            csum_err_q   <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= uart_rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            ld_state_q   <= ld_state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_buf_q   <= word_buf_d;
            word_cnt_q   <= word_cnt_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            load_done_q  <= load_done_d;
`ifdef UART_LDR_CHECKSUM_EN
            sum_q        <= sum_d;
            csum_err_q   <= csum_err_d;
`endif
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign load_done  = load_done_q;
    assign frame_err  = frame_err_q;
`ifdef UART_LDR_CHECKSUM_EN
    assign csum_err   = csum_err_q;
`else
    assign csum_err   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: directed vector table, glitch/reset sequences
// and a randomized full-image load checked against a byte-list model.
module tb_uart_imem_loader;
    localparam int CPB   = 16;
    localparam int WORDS = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          uart_rx;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst, load_done, frame_err, csum_err;

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .WORDS(WORDS), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .load_done(load_done),
        .frame_err(frame_err), .csum_err(csum_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          crst;
        int            c;
    } wr_t;
    wr_t wr_q[$];
    int  done_cyc = -1;

    always @(negedge clk) begin
        if (imem_we) wr_q.push_back('{addr: imem_addr, data: imem_wdata, crst: core_rst, c: cyc});
        if (load_done && done_cyc < 0) done_cyc = cyc;
    end

    int n_tot  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        wr_q.delete();
        done_cyc = -1;
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  b[4];
        bit          bad_first;
        logic [31:0] exp_data;
        logic        exp_ferr;
    } vec_t;
    vec_t vt[4];

    // Loads a random image (optionally with dropped framing-error bytes interleaved);
    // the expected words and checksum come straight from the byte list.
    task automatic load_image(input bit with_bad, input int csum_delta, output logic [31:0] words[WORDS],
                              output bit any_bad);
        logic [7:0] img[WORDS*4];
        logic [7:0] sum;
        sum     = 8'd0;
        any_bad = 1'b0;
        for (int i = 0; i < WORDS * 4; i++) begin
            img[i] = 8'($urandom);
            sum    = sum + img[i];
        end
        for (int w = 0; w < WORDS; w++)
            words[w] = {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]};
        for (int i = 0; i < WORDS * 4; i++) begin
            if (with_bad && $urandom_range(0, 15) == 0) begin
                send_byte(8'($urandom), 1'b0);
                any_bad = 1'b1;
            end
            send_byte(img[i], 1'b1);
        end
`ifdef UART_LDR_CHECKSUM_EN
        send_byte(sum + 8'(csum_delta), 1'b1);
`else
        if (csum_delta != 0) $display("note: checksum byte not used in this build (sum %0h)", sum);
`endif
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] words[WORDS];
        bit          any_bad;
        int          nw;

        vt[0] = '{b: '{8'h13, 8'h05, 8'h00, 8'h00}, bad_first: 1'b0, exp_data: 32'h00000513, exp_ferr: 1'b0};
        vt[1] = '{b: '{8'hef, 8'hbe, 8'had, 8'hde}, bad_first: 1'b0, exp_data: 32'hdeadbeef, exp_ferr: 1'b0};
        vt[2] = '{b: '{8'h13, 8'h05, 8'h00, 8'h00}, bad_first: 1'b1, exp_data: 32'h00000513, exp_ferr: 1'b1};
        vt[3] = '{b: '{8'h00, 8'hff, 8'h00, 8'hff}, bad_first: 1'b1, exp_data: 32'hff00ff00, exp_ferr: 1'b1};

        // Idle after reset
        do_reset();
        repeat (100) @(posedge clk);
        #1;
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_csum_err", 32'(csum_err), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_no_we", 32'(wr_q.size()), 32'd0);

        // Single-word vectors, some preceded by a framing-error byte
        for (int v = 0; v < 4; v++) begin
            do_reset();
            if (vt[v].bad_first) send_byte(8'h13, 1'b0);
            for (int k = 0; k < 4; k++) send_byte(vt[v].b[k], 1'b1);
            repeat (4) @(posedge clk);
            #1;
            chk($sformatf("v%0d_nwr", v), 32'(wr_q.size()), 32'd1);
            if (wr_q.size() > 0) begin
                chk($sformatf("v%0d_addr", v), 32'(wr_q[0].addr), 32'd0);
                chk($sformatf("v%0d_data", v), wr_q[0].data, vt[v].exp_data);
            end
            chk($sformatf("v%0d_ferr", v), 32'(frame_err), 32'(vt[v].exp_ferr));
            chk($sformatf("v%0d_core_rst", v), 32'(core_rst), 32'd1);
            chk($sformatf("v%0d_load_done", v), 32'(load_done), 32'd0);
        end

        // Short low glitch, then reset after two bytes
        do_reset();
        uart_rx = 1'b0;
        repeat (CPB / 4) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (4 * CPB) @(posedge clk);
        #1;
        chk("glitch_nwr", 32'(wr_q.size()), 32'd0);
        chk("glitch_ferr", 32'(frame_err), 32'd0);
        send_byte(8'haa, 1'b1);
        send_byte(8'hbb, 1'b1);
        do_reset();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_nwr", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) begin
            chk("midrst_addr", 32'(wr_q[0].addr), 32'd0);
            chk("midrst_data", wr_q[0].data, 32'h44332211);
        end

        // Full random image with interleaved dropped bytes
        do_reset();
        load_image(1'b1, 0, words, any_bad);
        nw = wr_q.size();
        chk("img_nwr", 32'(nw), 32'(WORDS));
        for (int i = 0; i < WORDS && i < nw; i++) begin
            chk($sformatf("img_addr%0d", i), 32'(wr_q[i].addr), 32'(i));
            chk($sformatf("img_data%0d", i), wr_q[i].data, words[i]);
        end
        if (nw > 0) chk("img_last_crst", 32'(wr_q[nw-1].crst), 32'd1);
`ifndef UART_LDR_CHECKSUM_EN
        if (nw > 0) chk("img_done_lat", 32'(done_cyc - wr_q[nw-1].c), 32'd1);
`endif
        chk("img_load_done", 32'(load_done), 32'd1);
        chk("img_core_rst", 32'(core_rst), 32'd0);
        chk("img_csum_err", 32'(csum_err), 32'd0);
        chk("img_ferr", 32'(frame_err), 32'(any_bad));
        send_byte(8'h5a, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("img_extra_nwr", 32'(wr_q.size()), 32'(WORDS));
        chk("img_extra_done", 32'(load_done), 32'd1);

`ifdef UART_LDR_CHECKSUM_EN
        // Checksum off by one holds the core in reset
        do_reset();
        load_image(1'b0, 1, words, any_bad);
        chk("bad_csum_nwr", 32'(wr_q.size()), 32'(WORDS));
        chk("bad_csum_err", 32'(csum_err), 32'd1);
        chk("bad_csum_core_rst", 32'(core_rst), 32'd1);
        chk("bad_csum_load_done", 32'(load_done), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
